// File: rtl/axis_arb_user_sq.sv
// axis_arb_user_sq: round-robin merge of per-source request descriptors and their data streams.
// Define AXIS_ARB_TLAST_CHECK_EN to build the sticky tlast/length mismatch check (err_tlast).
module axis_arb_user_sq #(
    parameter int N_SRCS        = 2,
    parameter int DATA_BITS     = 512,
    parameter int REQ_BITS      = 128,
    parameter int BLEN_BITS     = 28,
    parameter int BEAT_LOG_BITS = 6,
    localparam int SRC_BITS     = (N_SRCS > 1) ? $clog2(N_SRCS) : 1,
    localparam int KEEP_BITS    = DATA_BITS / 8
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [N_SRCS-1:0]           s_sq_valid,
    output logic [N_SRCS-1:0]           s_sq_ready,
    input  logic [N_SRCS*REQ_BITS-1:0]  s_sq_data,
    input  logic [N_SRCS-1:0]           s_axis_tvalid,
    output logic [N_SRCS-1:0]           s_axis_tready,
    input  logic [N_SRCS*DATA_BITS-1:0] s_axis_tdata,
    input  logic [N_SRCS*KEEP_BITS-1:0] s_axis_tkeep,
    input  logic [N_SRCS-1:0]           s_axis_tlast,
    output logic                        m_sq_valid,
    input  logic                        m_sq_ready,
    output logic [REQ_BITS-1:0]         m_sq_data,
    output logic [SRC_BITS-1:0]         m_sq_src,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [DATA_BITS-1:0]        m_axis_tdata,
    output logic [KEEP_BITS-1:0]        m_axis_tkeep,
    output logic                        m_axis_tlast,
    output logic [SRC_BITS-1:0]         m_axis_tid,
    output logic                        err_tlast
);

    typedef enum logic {
        ST_IDLE,
        ST_XFER
    } state_t;

    localparam logic [SRC_BITS:0] N_W = (SRC_BITS + 1)'(N_SRCS);

    state_t                state;
    state_t                state_nxt;
    logic [SRC_BITS-1:0]   rr_ptr;
    logic [SRC_BITS-1:0]   sel;
    logic [BLEN_BITS-1:0]  cnt;

    logic [2*N_SRCS-1:0]   req_dbl;
    logic [N_SRCS-1:0]     req_rot;
    logic [SRC_BITS:0]     rr_sum;
    logic                  gnt_any;
    logic [SRC_BITS-1:0]   gnt_idx;
    logic [REQ_BITS-1:0]   gnt_data;
    logic [BLEN_BITS-1:0]  gnt_len;
    logic [BLEN_BITS-1:0]  gnt_cnt;
    logic [SRC_BITS:0]     ptr_inc;
    logic [SRC_BITS-1:0]   ptr_nxt;

    logic                  xfer;
    logic                  beat_hs;
    logic                  last_hs;
    logic                  slot_free;
    logic                  gnt;

    // Rotate requests so bit 0 is rr_ptr; the lowest set bit wins.
    assign req_dbl = {s_sq_valid, s_sq_valid} >> rr_ptr;
    assign req_rot = req_dbl[N_SRCS-1:0];

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        rr_sum  = '0;
        for (int i = N_SRCS - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                gnt_any = 1'b1;
                rr_sum  = {1'b0, rr_ptr} + (SRC_BITS + 1)'(i);
                if (rr_sum >= N_W) begin
                    rr_sum = rr_sum - N_W;
                end
                gnt_idx = rr_sum[SRC_BITS-1:0];
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < N_SRCS; i++) begin
            if (gnt_idx == SRC_BITS'(i)) begin
                gnt_data = s_sq_data[i*REQ_BITS +: REQ_BITS];
            end
        end
    end

    assign gnt_len = gnt_data[BLEN_BITS-1:0];
    assign gnt_cnt = (gnt_len - BLEN_BITS'(1)) >> BEAT_LOG_BITS;
    assign ptr_inc = {1'b0, gnt_idx} + (SRC_BITS + 1)'(1);
    assign ptr_nxt = (ptr_inc >= N_W) ? '0 : ptr_inc[SRC_BITS-1:0];

    assign xfer      = (state == ST_XFER) && aresetn;
    assign beat_hs   = m_axis_tvalid && m_axis_tready;
    assign last_hs   = beat_hs && (cnt == '0);
    assign slot_free = !m_sq_valid || m_sq_ready;
    // A new grant may overlap the final beat so transfers run without a bubble.
    assign gnt = aresetn && slot_free && gnt_any &&
                 ((state == ST_IDLE) || last_hs);

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (gnt && (gnt_len != '0)) begin
                    state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                if (gnt) begin
                    state_nxt = (gnt_len != '0) ? ST_XFER : ST_IDLE;
                end else if (last_hs) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        s_sq_ready    = '0;
        s_axis_tready = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tid    = sel;
        for (int i = 0; i < N_SRCS; i++) begin
            if (gnt && (gnt_idx == SRC_BITS'(i))) begin
                s_sq_ready[i] = 1'b1;
            end
            if (xfer && (sel == SRC_BITS'(i))) begin
                m_axis_tvalid    = s_axis_tvalid[i];
                m_axis_tdata     = s_axis_tdata[i*DATA_BITS +: DATA_BITS];
                m_axis_tkeep     = s_axis_tkeep[i*KEEP_BITS +: KEEP_BITS];
                m_axis_tlast     = s_axis_tlast[i];
                s_axis_tready[i] = m_axis_tready;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            sel        <= '0;
            cnt        <= '0;
            m_sq_valid <= 1'b0;
            m_sq_data  <= '0;
            m_sq_src   <= '0;
        end else begin
            state <= state_nxt;
            if (gnt) begin
                rr_ptr     <= ptr_nxt;
                sel        <= gnt_idx;
                cnt        <= gnt_cnt;
                m_sq_valid <= 1'b1;
                m_sq_data  <= gnt_data;
                m_sq_src   <= gnt_idx;
            end else begin
                if (m_sq_ready) begin
                    m_sq_valid <= 1'b0;
                end
                if (beat_hs) begin
                    cnt <= cnt - BLEN_BITS'(1);
                end
            end
        end
    end

`ifdef AXIS_ARB_TLAST_CHECK_EN
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            err_tlast <= 1'b0;
        end else if (beat_hs && (m_axis_tlast != (cnt == '0))) begin
            err_tlast <= 1'b1;
        end
    end
`else
    assign err_tlast = 1'b0;
`endif

endmodule

// File: tb/tb_axis_arb_user_sq.sv
// tb_axis_arb_user_sq: directed scenarios for axis_arb_user_sq against a
// transaction-level model of arbitration, descriptor forwarding and beat routing.
module tb_axis_arb_user_sq;

    localparam int N   = 2;
    localparam int DB  = 512;
    localparam int RB  = 128;
    localparam int KB  = DB / 8;
    localparam int BPB = 64;

    typedef struct {
        int len;
        int tag;
        int tl_at;
    } req_t;

    typedef struct {
        int cyc;
        int src;
        bit last;
    } ev_t;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic [N-1:0]    s_sq_valid = '0;
    logic [N-1:0]    s_sq_ready;
    logic [N*RB-1:0] s_sq_data = '0;
    logic [N-1:0]    s_axis_tvalid = '0;
    logic [N-1:0]    s_axis_tready;
    logic [N*DB-1:0] s_axis_tdata = '0;
    logic [N*KB-1:0] s_axis_tkeep = '0;
    logic [N-1:0]    s_axis_tlast = '0;
    logic            m_sq_valid;
    logic            m_sq_ready = 1'b1;
    logic [RB-1:0]   m_sq_data;
    logic [0:0]      m_sq_src;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b1;
    logic [DB-1:0]   m_axis_tdata;
    logic [KB-1:0]   m_axis_tkeep;
    logic            m_axis_tlast;
    logic [0:0]      m_axis_tid;
    logic            err_tlast;

    axis_arb_user_sq dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_sq_valid    (s_sq_valid),
        .s_sq_ready    (s_sq_ready),
        .s_sq_data     (s_sq_data),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .m_sq_valid    (m_sq_valid),
        .m_sq_ready    (m_sq_ready),
        .m_sq_data     (m_sq_data),
        .m_sq_src      (m_sq_src),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tid    (m_axis_tid),
        .err_tlast     (err_tlast)
    );

    always #5 aclk = ~aclk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    req_t sq_q[N][$];
    req_t dq[N][$];
    int   bi[N];
    logic [N-1:0] hs_sq = '0;
    logic [N-1:0] hs_ax = '0;
    bit   rst_flag = 1'b0;

    ev_t glog[$];
    ev_t blog[$];
    int  tr1_cnt = 0;

    // Model state: active transfer, pending descriptor, round-robin pointer.
    int            m_rem = 0;
    int            m_src = 0;
    int            m_tag = 0;
    int            m_bi = 0;
    int            m_tlat = 0;
    bit            mq_v = 1'b0;
    logic [RB-1:0] mq_data = '0;
    int            mq_src = 0;
    int            m_rr = 0;
    bit            m_err = 1'b0;

    task automatic chk(input string nm, input logic [DB-1:0] act,
                       input logic [DB-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [RB-1:0] desc(input req_t r);
        logic [RB-1:0] d;
        d = '0;
        d[27:0]  = 28'(r.len);
        d[63:32] = 32'(r.tag);
        return d;
    endfunction

    function automatic logic [DB-1:0] pat(input int tag, input int b);
        return {16{tag[15:0], b[15:0]}};
    endfunction

    function automatic logic [KB-1:0] kpat(input int tag, input int b);
        return {8{tag[7:0] ^ b[7:0]}};
    endfunction

    function automatic int beats(input int len);
        return (len + BPB - 1) / BPB;
    endfunction

    function automatic int rr_win(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    // Compare process: checks every cycle, then advances the model.
    always @(negedge aclk) begin
        int w;
        bit ev;
        bit beat;
        bit fin;
        bit can;
        cyc++;
        if (!aresetn) begin
            chk("rst_s_sq_ready", s_sq_ready, '0);
            chk("rst_s_axis_tready", s_axis_tready, '0);
            m_rem = 0;
            mq_v = 1'b0;
            m_rr = 0;
            m_err = 1'b0;
            rst_flag = 1'b1;
        end else begin
            chk("m_sq_valid", m_sq_valid, mq_v);
            if (mq_v) begin
                chk("m_sq_data", m_sq_data, mq_data);
                chk("m_sq_src", m_sq_src, mq_src);
            end
            ev = (m_rem > 0) ? s_axis_tvalid[m_src] : 1'b0;
            chk("m_axis_tvalid", m_axis_tvalid, ev);
            chk("s_axis_tready", s_axis_tready,
                (m_rem > 0) ? (N'(m_axis_tready) << m_src) : '0);
            if (ev) begin
                chk("m_axis_tid", m_axis_tid, m_src);
                chk("m_axis_tdata", m_axis_tdata, pat(m_tag, m_bi));
                chk("m_axis_tkeep", m_axis_tkeep, kpat(m_tag, m_bi));
                chk("m_axis_tlast", m_axis_tlast, m_bi == m_tlat);
            end
            beat = ev && m_axis_tready;
            fin = beat && (m_rem == 1);
            w = rr_win(s_sq_valid, m_rr);
            can = ((m_rem == 0) || fin) && (!mq_v || m_sq_ready) && (|s_sq_valid);
            chk("s_sq_ready", s_sq_ready, can ? (N'(1) << w) : '0);
            chk("err_tlast", err_tlast, m_err);
            if (s_axis_tready[1]) tr1_cnt++;
            if (beat) begin
`ifdef AXIS_ARB_TLAST_CHECK_EN
                if ((m_bi == m_tlat) != (m_rem == 1)) m_err = 1'b1;
`endif
                blog.push_back('{cyc, m_src, m_bi == m_tlat});
                m_rem--;
                m_bi++;
            end
            if (mq_v && m_sq_ready) mq_v = 1'b0;
            if (can && sq_q[w].size() > 0) begin
                req_t r;
                r = sq_q[w][0];
                mq_v = 1'b1;
                mq_data = desc(r);
                mq_src = w;
                m_rr = (w + 1) % N;
                if (r.len != 0) begin
                    m_rem = beats(r.len);
                    m_src = w;
                    m_tag = r.tag;
                    m_bi = 0;
                    m_tlat = r.tl_at;
                end
            end
            if (|s_sq_ready) begin
                glog.push_back('{cyc, s_sq_ready[1] ? 1 : 0, 1'b0});
            end
            hs_sq = s_sq_valid & s_sq_ready;
            hs_ax = s_axis_tvalid & s_axis_tready;
        end
    end

    // Source drivers: descriptor queue per source, then its beats after grant.
    always @(posedge aclk) begin
        #2;
        for (int i = 0; i < N; i++) begin
            if (rst_flag) begin
                sq_q[i].delete();
                dq[i].delete();
                bi[i] = 0;
            end else begin
                if (hs_ax[i] && dq[i].size() > 0) begin
                    bi[i]++;
                    if (bi[i] >= beats(dq[i][0].len)) begin
                        void'(dq[i].pop_front());
                        bi[i] = 0;
                    end
                end
                if (hs_sq[i] && sq_q[i].size() > 0) begin
                    req_t r;
                    r = sq_q[i].pop_front();
                    if (r.len != 0) dq[i].push_back(r);
                end
            end
            s_sq_valid[i] = sq_q[i].size() > 0;
            s_sq_data[i*RB +: RB] = (sq_q[i].size() > 0) ? desc(sq_q[i][0]) : '0;
            s_axis_tvalid[i] = dq[i].size() > 0;
            if (dq[i].size() > 0) begin
                s_axis_tdata[i*DB +: DB] = pat(dq[i][0].tag, bi[i]);
                s_axis_tkeep[i*KB +: KB] = kpat(dq[i][0].tag, bi[i]);
                s_axis_tlast[i] = (bi[i] == dq[i][0].tl_at);
            end else begin
                s_axis_tdata[i*DB +: DB] = '0;
                s_axis_tkeep[i*KB +: KB] = '0;
                s_axis_tlast[i] = 1'b0;
            end
        end
        rst_flag = 1'b0;
        hs_sq = '0;
        hs_ax = '0;
    end

    task automatic push(input int src, input int len, input int tag,
                        input int tl_at = -1);
        req_t r;
        r.len = len;
        r.tag = tag;
        r.tl_at = (tl_at < 0) ? beats(len) - 1 : tl_at;
        sq_q[src].push_back(r);
    endtask

    task automatic step();
        @(posedge aclk);
        #3;
    endtask

    task automatic clr_logs();
        glog.delete();
        blog.delete();
        tr1_cnt = 0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (n < 200) begin
            step();
            n++;
            if (sq_q[0].size() == 0 && sq_q[1].size() == 0 &&
                dq[0].size() == 0 && dq[1].size() == 0 &&
                m_rem == 0 && !mq_v) break;
        end
        chk({nm, "_timeout"}, n >= 200, 1'b0);
    endtask

    initial begin
        repeat (3) step();
        aresetn = 1'b1;
        chk("reset_m_sq_valid", m_sq_valid, 1'b0);
        chk("reset_m_axis_tvalid", m_axis_tvalid, 1'b0);
        chk("reset_err_tlast", err_tlast, 1'b0);

        // Both sources saturated with single-beat requests.
        clr_logs();
        push(0, 64, 16'h101); push(0, 64, 16'h102);
        push(1, 64, 16'h201); push(1, 64, 16'h202);
        wait_idle("alt");
        chk("alt_grants", glog.size(), 4);
        chk("alt_order", {glog[0].src[0], glog[1].src[0], glog[2].src[0],
                          glog[3].src[0]}, 4'b0101);
        chk("alt_beats", blog.size(), 4);
        chk("alt_no_bubble", blog[3].cyc - blog[0].cyc, 3);

        // Two-beat request from source 0.
        clr_logs();
        push(0, 128, 16'h0a1);
        wait_idle("two");
        chk("two_beats", blog.size(), 2);
        chk("two_first_beat_lat", blog[0].cyc - glog[0].cyc, 1);
        chk("two_tids", {blog[0].src[0], blog[1].src[0]}, 2'b00);
        chk("two_tlast", {blog[0].last, blog[1].last}, 2'b01);

        // Zero-length request on source 1 frees the arbiter at once.
        clr_logs();
        push(1, 0, 16'h0b1);
        push(0, 64, 16'h0b2);
        wait_idle("zero");
        chk("zero_grants", glog.size(), 2);
        chk("zero_first_src", glog[0].src, 1);
        chk("zero_next_grant", glog[1].cyc - glog[0].cyc, 1);
        chk("zero_src1_tready", tr1_cnt, 0);
        chk("zero_beats", blog.size(), 1);

        // Stalled descriptor output blocks further grants.
        clr_logs();
        m_sq_ready = 1'b0;
        push(1, 0, 16'h0c1);
        push(0, 64, 16'h0c2);
        repeat (6) step();
        chk("stall_grants", glog.size(), 1);
        chk("stall_m_sq_data", m_sq_data, 128'h0000_0000_0000_0c1_0_0000000);
        chk("stall_m_sq_src", m_sq_src, 1'b1);
        m_sq_ready = 1'b1;
        wait_idle("stall");
        chk("stall_grants_after", glog.size(), 2);
        chk("stall_second_src", glog[1].src, 0);

        // Three beats with tlast on the second one.
        clr_logs();
        push(0, 192, 16'h0d1, 1);
        wait_idle("tlast");
        chk("tlast_beats", blog.size(), 3);
`ifdef AXIS_ARB_TLAST_CHECK_EN
        chk("tlast_err_set", err_tlast, 1'b1);
`else
        chk("tlast_err_off", err_tlast, 1'b0);
`endif

        // Reset after first of four beats.
        clr_logs();
        push(0, 256, 16'h0e1);
        for (int n = 0; n < 50 && blog.size() < 1; n++) step();
        chk("rst_beat1_seen", blog.size(), 1);
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        chk("rst_m_sq_valid", m_sq_valid, 1'b0);
        chk("rst_m_axis_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_tready", s_axis_tready, 2'b00);
        chk("rst_sq_ready", s_sq_ready, 2'b00);
        chk("rst_err", err_tlast, 1'b0);
        clr_logs();
        push(0, 64, 16'h0f1);
        push(1, 64, 16'h0f2);
        wait_idle("post_rst");
        chk("post_rst_first_src", glog[0].src, 0);
        chk("post_rst_beats", blog.size(), 2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
